// File: rtl/mem_access_unit.sv
// Memory-stage data access unit: drives a req/ack data bus for loads and stores,
// aligns store lanes, formats load data and stalls the pipeline while a transfer is pending.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        InterruptRequest,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemTypeM,
  input  logic        LoadExtSignM,
  input  logic        LeftRightM,
  input  logic [31:0] AddrM,
  input  logic [31:0] RtValueM,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusByteEn,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData,
  output logic        StallM,
  output logic        AddrErrM,
  output logic [31:0] ReadDataW,
  output logic        ReadValidW
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic        flush_q, flush_d;
  logic [1:0]  ld_type_q, ld_type_d;
  logic        ld_sext_q, ld_sext_d;
  logic        ld_left_q, ld_left_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [31:0] ld_rt_q, ld_rt_d;

  logic        op;
  logic [1:0]  n;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  // Lane select / extension for byte and half loads, byte merge for LWL/LWR.
  function automatic logic [31:0] format_load(input logic [1:0]  mtype,
                                              input logic        sext,
                                              input logic        left,
                                              input logic [1:0]  off,
                                              input logic [31:0] w,
                                              input logic [31:0] rt);
    logic [31:0] sh;
    logic [31:0] res;
    sh = w >> {off, 3'b000};
    case (mtype)
      2'b01:   res = {{16{sext & sh[15]}}, sh[15:0]};
      2'b10:   res = {{24{sext & sh[7]}}, sh[7:0]};
      2'b11: begin
        if (left) res = (w << {~off, 3'b000}) | (rt & ~(32'hFFFF_FFFF << {~off, 3'b000}));
        else      res = sh | (rt & ~(32'hFFFF_FFFF >> {off, 3'b000}));
      end
      default: res = w;
    endcase
    return res;
  endfunction

  assign n        = AddrM[1:0];
  assign op       = MemtoRegM | MemWriteM;
  assign AddrErrM = op & (((MemTypeM == 2'b00) & (n != 2'b00)) | ((MemTypeM == 2'b01) & n[0]));

  always_comb begin
    st_be   = 4'b1111;
    st_data = RtValueM;
    case (MemTypeM)
      2'b01: begin st_be = 4'b0011 << n; st_data = {2{RtValueM[15:0]}}; end
      2'b10: begin st_be = 4'b0001 << n; st_data = {4{RtValueM[7:0]}}; end
      2'b11: begin
        if (LeftRightM) begin
          st_be   = 4'b1111 >> ~n;
          st_data = RtValueM >> {~n, 3'b000};
        end else begin
          st_be   = 4'b1111 << n;
          st_data = RtValueM << {n, 3'b000};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    read_data_d  = read_data_q;
    read_valid_d = read_valid_q;
    flush_d      = flush_q;
    ld_type_d    = ld_type_q;
    ld_sext_d    = ld_sext_q;
    ld_left_d    = ld_left_q;
    ld_off_d     = ld_off_q;
    ld_rt_d      = ld_rt_q;
    StallM       = 1'b0;
    case (state_q)
      IDLE: begin
        if (op && !AddrErrM && !InterruptRequest) begin
          StallM      = 1'b1;
          state_d     = REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = MemWriteM;
          bus_addr_d  = {AddrM[31:2], 2'b00};
          bus_be_d    = MemWriteM ? st_be : 4'b1111;
          bus_wdata_d = MemWriteM ? st_data : 32'h0;
          flush_d     = 1'b0;
          // Load context is captured so the flushed carriers cannot corrupt the result.
          ld_type_d   = MemTypeM;
          ld_sext_d   = LoadExtSignM;
          ld_left_d   = LeftRightM;
          ld_off_d    = n;
          ld_rt_d     = RtValueM;
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (InterruptRequest) flush_d = 1'b1;
        if (BusAck) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (!bus_we_q && !(flush_q || InterruptRequest)) begin
            read_data_d  = format_load(ld_type_q, ld_sext_q, ld_left_q, ld_off_q, BusRData, ld_rt_q);
            read_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        read_valid_d = 1'b0;
        flush_d      = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) StallM = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_be_q     <= 4'h0;
      bus_wdata_q  <= 32'h0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      ld_type_q    <= 2'b00;
      ld_sext_q    <= 1'b0;
      ld_left_q    <= 1'b0;
      ld_off_q     <= 2'b00;
      ld_rt_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      flush_q      <= flush_d;
      ld_type_q    <= ld_type_d;
      ld_sext_q    <= ld_sext_d;
      ld_left_q    <= ld_left_d;
      ld_off_q     <= ld_off_d;
      ld_rt_q      <= ld_rt_d;
    end
  end

  assign BusReq     = bus_req_q;
  assign BusWe      = bus_we_q;
  assign BusAddr    = bus_addr_q;
  assign BusByteEn  = bus_be_q;
  assign BusWData   = bus_wdata_q;
  assign ReadDataW  = read_data_q;
  assign ReadValidW = read_valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table for single transfers,
// scoreboard queue for load results, hand sequences for flush and reset corners.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        InterruptRequest;
  logic        MemtoRegM, MemWriteM;
  logic [1:0]  MemTypeM;
  logic        LoadExtSignM, LeftRightM;
  logic [31:0] AddrM, RtValueM;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr;
  logic [3:0]  BusByteEn;
  logic [31:0] BusWData;
  logic        BusAck;
  logic [31:0] BusRData;
  logic        StallM, AddrErrM;
  logic [31:0] ReadDataW;
  logic        ReadValidW;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .InterruptRequest(InterruptRequest),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .MemTypeM(MemTypeM),
    .LoadExtSignM(LoadExtSignM), .LeftRightM(LeftRightM),
    .AddrM(AddrM), .RtValueM(RtValueM),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusByteEn(BusByteEn),
    .BusWData(BusWData), .BusAck(BusAck), .BusRData(BusRData),
    .StallM(StallM), .AddrErrM(AddrErrM), .ReadDataW(ReadDataW), .ReadValidW(ReadValidW)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  mtype;
    logic        sext;
    logic        left;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          waits;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 18;
  vec_t        vecs [NV];
  logic [31:0] exp_q [$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, {31'b0, act}, {31'b0, req});
  endtask

  // Scoreboard: every load result the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ReadValidW) begin
      if (exp_q.size() == 0) chk1("unexpected_valid", ReadValidW, 1'b0);
      else                   chk("load_data", ReadDataW, exp_q.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemtoRegM = 1'b0; MemWriteM = 1'b0; InterruptRequest = 1'b0;
    MemTypeM = 2'b00; LoadExtSignM = 1'b0; LeftRightM = 1'b0;
    AddrM = 32'h0; RtValueM = 32'h0; BusAck = 1'b0; BusRData = 32'h0;
  endtask

  task automatic drive_op(input vec_t v);
    MemtoRegM = v.ld; MemWriteM = v.st; MemTypeM = v.mtype;
    LoadExtSignM = v.sext; LeftRightM = v.left; AddrM = v.addr; RtValueM = v.rt;
  endtask

  // Called just after a posedge with the DUT idle; returns at the negedge of an idle cycle.
  task automatic run_vec(input vec_t v);
    drive_op(v);
    @(negedge clk);
    chk1("addr_err", AddrErrM, v.exp_err);
    chk1("stall_c0", StallM, !v.exp_err);
    if (v.exp_err) begin
      for (int i = 0; i < 3; i++) begin
        next_cycle();
        @(negedge clk);
        chk1("err_no_req", BusReq, 1'b0);
        chk1("err_no_stall", StallM, 1'b0);
      end
      idle_inputs();
    end else begin
      next_cycle();
      @(negedge clk);
      chk1("req_c1", BusReq, 1'b1);
      chk1("bus_we", BusWe, v.st);
      chk("bus_addr", BusAddr, {v.addr[31:2], 2'b00});
      chk("bus_be", {28'b0, BusByteEn}, {28'b0, v.exp_be});
      if (v.st) chk("bus_wdata", BusWData, v.exp_wdata);
      else      exp_q.push_back(v.exp_rd);
      chk1("stall_req", StallM, 1'b1);
      for (int k = 0; k < v.waits; k++) begin
        next_cycle();
        @(negedge clk);
        chk1("req_wait", BusReq, 1'b1);
        chk1("stall_wait", StallM, 1'b1);
        chk1("valid_early", ReadValidW, 1'b0);
      end
      BusAck = 1'b1;
      BusRData = v.rdata;
      next_cycle();
      BusAck = 1'b0;
      BusRData = 32'h0;
      @(negedge clk);
      chk1("req_done", BusReq, 1'b0);
      chk1("stall_done", StallM, 1'b0);
      chk1("valid_done", ReadValidW, !v.st);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk1("valid_idle", ReadValidW, 1'b0);
      chk1("stall_idle", StallM, 1'b0);
    end
  endtask

  initial begin
    //          ld    st    type   sext  left  addr          rt            rdata        w  err   be       wdata         rd
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        2, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h80112233, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_0102, 32'h0,        32'h80112233, 1, 1'b0, 4'b1111, 32'h0,        32'h00008011};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0000_0101, 32'hAABBCCDD, 32'h11223344, 0, 1'b0, 4'b1111, 32'h0,        32'h3344CCDD};
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h0000_0101, 32'hAABBCCDD, 32'h11223344, 0, 1'b0, 4'b1111, 32'h0,        32'hAA112233};
    vecs[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0101, 32'h12345678, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0102, 32'h000000A5, 32'h0,        1, 1'b0, 4'b0100, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0102, 32'h1234BEEF, 32'h0,        0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0101, 32'h11223344, 32'h0,        0, 1'b0, 4'b0011, 32'h00001122, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0000_0101, 32'h11223344, 32'h0,        0, 1'b0, 4'b1110, 32'h22334400, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        32'hCAFEF00D, 0, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0106, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0101, 32'h0,        32'h80112233, 0, 1'b0, 4'b1111, 32'h0,        32'h00000022};
    vecs[13] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'h1234F00D, 2, 1'b0, 4'b1111, 32'h0,        32'hFFFFF00D};
    vecs[14] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0000_0103, 32'hAABBCCDD, 32'h11223344, 0, 1'b0, 4'b1111, 32'h0,        32'h11223344};
    vecs[15] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0000_0100, 32'hAABBCCDD, 32'h11223344, 0, 1'b0, 4'b1111, 32'h0,        32'h44BBCCDD};
    vecs[16] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h0000_0103, 32'hAABBCCDD, 32'h11223344, 1, 1'b0, 4'b1111, 32'h0,        32'hAABBCC11};
    vecs[17] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0108, 32'h0BADF00D, 32'h0,        0, 1'b0, 4'b1111, 32'h0BADF00D, 32'h0};

    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk1("rst_req", BusReq, 1'b0);
    chk1("rst_we", BusWe, 1'b0);
    chk("rst_addr", BusAddr, 32'h0);
    chk("rst_be", {28'b0, BusByteEn}, 32'h0);
    chk("rst_wdata", BusWData, 32'h0);
    chk("rst_rdata", ReadDataW, 32'h0);
    chk1("rst_valid", ReadValidW, 1'b0);
    chk1("rst_stall", StallM, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      next_cycle();
      run_vec(vecs[i]);
    end

    // Flush while the bus is busy: the access completes but yields no result.
    next_cycle();
    MemtoRegM = 1'b1; MemTypeM = 2'b00; AddrM = 32'h0000_0200;
    @(negedge clk);
    chk1("fl_stall_c0", StallM, 1'b1);
    next_cycle();
    InterruptRequest = 1'b1;
    @(negedge clk);
    chk1("fl_req_c1", BusReq, 1'b1);
    chk1("fl_stall_c1", StallM, 1'b1);
    next_cycle();
    InterruptRequest = 1'b0;
    MemtoRegM = 1'b0;
    AddrM = 32'h0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk1("fl_req_held", BusReq, 1'b1);
      chk("fl_addr_held", BusAddr, 32'h0000_0200);
      chk1("fl_stall_held", StallM, 1'b1);
      if (c < 4) next_cycle();
    end
    BusAck = 1'b1;
    BusRData = 32'h5555AAAA;
    next_cycle();
    BusAck = 1'b0;
    @(negedge clk);
    chk1("fl_req_drop", BusReq, 1'b0);
    chk1("fl_valid_done", ReadValidW, 1'b0);
    chk1("fl_stall_done", StallM, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk1("fl_valid_idle", ReadValidW, 1'b0);

    // Flush while idle: the op never reaches the bus.
    next_cycle();
    MemtoRegM = 1'b1; MemTypeM = 2'b00; AddrM = 32'h0000_0204; InterruptRequest = 1'b1;
    @(negedge clk);
    chk1("irq_idle_stall", StallM, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("irq_idle_req", BusReq, 1'b0);
    idle_inputs();

    // Reset during a pending transfer abandons it.
    next_cycle();
    MemWriteM = 1'b1; MemTypeM = 2'b00; AddrM = 32'h0000_0300; RtValueM = 32'h12345678;
    next_cycle();
    @(negedge clk);
    chk1("rr_req", BusReq, 1'b1);
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    chk1("rr_req_after", BusReq, 1'b0);
    chk1("rr_we_after", BusWe, 1'b0);
    chk("rr_addr_after", BusAddr, 32'h0);
    chk("rr_be_after", {28'b0, BusByteEn}, 32'h0);
    chk("rr_wdata_after", BusWData, 32'h0);
    chk("rr_rdata_after", ReadDataW, 32'h0);
    chk1("rr_valid_after", ReadValidW, 1'b0);
    chk1("rr_stall_after", StallM, 1'b0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    @(negedge clk);
    chk1("rr_idle_req", BusReq, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
